// File: rtl/fifo_sync_mc.sv
// fifo_sync_mc: G_CH independent synchronous FIFOs of G_D words sharing one G_CH*G_D-word memory
// Ports: i_clk/i_arst_n clock and async active-low reset; i_sclr/i_chclr global and per-channel clears;
//   i_wena/i_wch/i_wdat write port; i_rena/i_rch read request with 1-cycle latency returning o_rvld/o_rch/o_rdat;
//   o_empt/o_full/o_alme/o_almf/o_flvl per-channel status; o_ovf/o_udf sticky per-channel errors.
module fifo_sync_mc #(
  parameter int G_CH = 4,
  parameter int G_D = 16,
  parameter int G_W = 32,
  parameter int AFULL_LEVEL = 12,
  parameter int AEMPTY_LEVEL = 2,
  parameter int CW = $clog2(G_CH),
  parameter int AW = $clog2(G_D)
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_sclr,
  input  logic [G_CH-1:0]        i_chclr,
  input  logic                   i_wena,
  input  logic [CW-1:0]          i_wch,
  input  logic [G_W-1:0]         i_wdat,
  input  logic                   i_rena,
  input  logic [CW-1:0]          i_rch,
  output logic                   o_rvld,
  output logic [CW-1:0]          o_rch,
  output logic [G_W-1:0]         o_rdat,
  output logic [G_CH-1:0]        o_empt,
  output logic [G_CH-1:0]        o_full,
  output logic [G_CH-1:0]        o_alme,
  output logic [G_CH-1:0]        o_almf,
  output logic [G_CH*(AW+1)-1:0] o_flvl,
  output logic [G_CH-1:0]        o_ovf,
  output logic [G_CH-1:0]        o_udf
);
  logic [G_W-1:0] r_mem [G_CH*G_D];
  logic [AW-1:0] r_wptr [G_CH];
  logic [AW-1:0] r_rptr [G_CH];
  logic [AW:0] r_lvl [G_CH];
  logic [G_CH-1:0] r_ovf, r_udf;
  logic r_rvld;
  logic [CW-1:0] r_rch;
  logic [G_W-1:0] r_rdat;
  logic [G_CH-1:0] w_clr, w_winc, w_rinc, w_ovf, w_udf;
  logic w_win, w_rin, w_racc, w_wacc;
  logic [CW+AW-1:0] w_waddr, w_raddr;
  always_comb begin
    w_clr = {G_CH{i_sclr}} | i_chclr;
    w_win = int'(i_wch) < G_CH;
    w_rin = int'(i_rch) < G_CH;
    w_racc = i_rena & w_rin & ~o_empt[i_rch] & ~w_clr[i_rch];
    // a full channel still accepts a write when the same channel is drained this cycle
    w_wacc = i_wena & w_win & ~w_clr[i_wch] & (~o_full[i_wch] | (w_racc & (i_rch == i_wch)));
    w_waddr = {i_wch, r_wptr[i_wch]};
    w_raddr = {i_rch, r_rptr[i_rch]};
    for (int c = 0; c < G_CH; c++) begin
      w_winc[c] = w_wacc & (int'(i_wch) == c);
      w_rinc[c] = w_racc & (int'(i_rch) == c);
      w_ovf[c] = i_wena & (int'(i_wch) == c) & o_full[c] & ~w_winc[c];
      w_udf[c] = i_rena & (int'(i_rch) == c) & o_empt[c];
    end
  end
  always_ff @(posedge i_clk)
    if (w_wacc) r_mem[w_waddr] <= i_wdat;
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      for (int c = 0; c < G_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_lvl[c] <= '0;
      end
      r_ovf <= '0;
      r_udf <= '0;
      r_rvld <= 1'b0;
      r_rch <= '0;
      r_rdat <= '0;
    end else begin
      for (int c = 0; c < G_CH; c++) begin
        r_wptr[c] <= w_clr[c] ? '0 : r_wptr[c] + AW'(w_winc[c]);
        r_rptr[c] <= w_clr[c] ? '0 : r_rptr[c] + AW'(w_rinc[c]);
        r_lvl[c] <= w_clr[c] ? '0 : r_lvl[c] + (AW+1)'(w_winc[c]) - (AW+1)'(w_rinc[c]);
      end
      // clear masks both the held error and any error raised in the same cycle
      r_ovf <= ~w_clr & (r_ovf | w_ovf);
      r_udf <= ~w_clr & (r_udf | w_udf);
      r_rvld <= w_racc;
      if (w_racc) begin
        r_rch <= i_rch;
        r_rdat <= r_mem[w_raddr];
      end
    end
  for (genvar g = 0; g < G_CH; g++) begin : g_ch
    assign o_empt[g] = r_lvl[g] == '0;
    assign o_full[g] = int'(r_lvl[g]) == G_D;
    assign o_almf[g] = int'(r_lvl[g]) >= AFULL_LEVEL;
    assign o_alme[g] = int'(r_lvl[g]) <= AEMPTY_LEVEL;
    assign o_flvl[g*(AW+1) +: AW+1] = r_lvl[g];
  end
  assign o_rvld = r_rvld;
  assign o_rch = r_rch;
  assign o_rdat = r_rdat;
  assign o_ovf = r_ovf;
  assign o_udf = r_udf;
endmodule

// File: tb/tb_fifo_sync_mc.sv
// tb_fifo_sync_mc: directed stimulus with a read-data scoreboard for fifo_sync_mc
module tb_fifo_sync_mc;
  localparam int CH = 4, D = 16, W = 32, LW = 5;
  logic clk = 1'b0, arst_n = 1'b0, sclr = 1'b0, wena = 1'b0, rena = 1'b0;
  logic [CH-1:0] chclr = '0;
  logic [1:0] wch = '0, rch_i = '0;
  logic [W-1:0] wdat = '0;
  logic rvld;
  logic [1:0] rch;
  logic [W-1:0] rdat;
  logic [CH-1:0] empt, full, alme, almf, ovf, udf;
  logic [CH*LW-1:0] flvl;
  logic [33:0] q[$];
  logic [33:0] m_exp;
  int n_chk = 0, n_fail = 0;
  fifo_sync_mc #(.G_CH(CH), .G_D(D), .G_W(W), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_sclr(sclr), .i_chclr(chclr),
    .i_wena(wena), .i_wch(wch), .i_wdat(wdat), .i_rena(rena), .i_rch(rch_i),
    .o_rvld(rvld), .o_rch(rch), .o_rdat(rdat), .o_empt(empt), .o_full(full),
    .o_alme(alme), .o_almf(almf), .o_flvl(flvl), .o_ovf(ovf), .o_udf(udf)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  function automatic int lv(int c);
    return int'(flvl[c*LW +: LW]);
  endfunction
  always @(negedge clk)
    if (arst_n && rvld) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rvld_unexpected: got ch %0d data %0h, required no valid", rch, rdat);
      end else begin
        m_exp = q.pop_front();
        if ({rch, rdat} !== m_exp) begin
          n_fail++;
          $display("FAIL rdata: got ch %0d data %0h, required ch %0d data %0h", rch, rdat, m_exp[33:32], m_exp[31:0]);
        end
      end
    end
  task automatic cyc(bit we, int wc, int wd, bit re, int rc, bit ev, int ed);
    wena = we;
    wch = wc[1:0];
    wdat = wd;
    rena = re;
    rch_i = rc[1:0];
    if (ev) q.push_back({rc[1:0], ed});
    @(posedge clk);
    #1;
    wena = 1'b0;
    rena = 1'b0;
  endtask
  task automatic wr(int c, int d);
    cyc(1'b1, c, d, 1'b0, 0, 1'b0, 0);
  endtask
  task automatic rd(int c, int d);
    cyc(1'b0, 0, 0, 1'b1, c, 1'b1, d);
  endtask
  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empt", empt, 4'hf);
    chk("rst_full", full, 0);
    chk("rst_alme", alme, 4'hf);
    chk("rst_almf", almf, 0);
    chk("rst_flvl", flvl, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_rvld", rvld, 0);
    chk("rst_rch", rch, 0);
    chk("rst_rdat", rdat, 0);
    arst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) wr(1, 'hA0 + i);
    chk("t1_lvl4", lv(1), 4);
    chk("t1_notempty", empt[1], 0);
    for (int i = 0; i < 4; i++) rd(1, 'hA0 + i);
    chk("t1_lvl0", lv(1), 0);
    idle();
    chk("t1_empty", empt[1], 1);
    for (int i = 0; i < 16; i++) wr(2, 'h200 + i);
    chk("t2_full", full[2], 1);
    chk("t2_lvl16", lv(2), 16);
    chk("t2_almf", almf[2], 1);
    chk("t2_ovf_pre", ovf[2], 0);
    wr(2, 'h2FF);
    chk("t2_ovf", ovf[2], 1);
    chk("t2_lvl_after_ovf", lv(2), 16);
    cyc(1'b1, 2, 'h210, 1'b1, 2, 1'b1, 'h200);
    chk("t2_lvl_rw", lv(2), 16);
    chk("t2_full_rw", full[2], 1);
    for (int i = 1; i <= 16; i++) rd(2, (i == 16) ? 'h210 : 'h200 + i);
    chk("t2_drained", lv(2), 0);
    chk("t2_ovf_sticky", ovf[2], 1);
    for (int i = 0; i < 12; i++) wr(0, i);
    for (int i = 0; i < 24; i++)
      cyc(1'b1, (i % 2) ? 3 : 0, (i % 2) ? 'h300 + i : 12 + i / 2, 1'b1, 0, 1'b1, i);
    chk("t3_lvl0", lv(0), 0);
    chk("t3_lvl3", lv(3), 12);
    chk("t3_udf0", udf[0], 0);
    chk("t3_almf3", almf[3], 1);
    for (int k = 0; k < 12; k++) rd(3, 'h301 + 2 * k);
    chk("t3_lvl3_drained", lv(3), 0);
    cyc(1'b0, 0, 0, 1'b1, 1, 1'b0, 0);
    chk("t4_udf1", udf[1], 1);
    chk("t4_lvl1_empty", lv(1), 0);
    cyc(1'b1, 1, 'hC1, 1'b1, 1, 1'b0, 0);
    chk("t4_lvl1_nobypass", lv(1), 1);
    rd(1, 'hC1);
    idle();
    for (int i = 0; i < 5; i++) begin
      wr(0, 'hD0 + i);
      wr(2, 'hE0 + i);
    end
    chk("t5_lvl0", lv(0), 5);
    chk("t5_lvl2", lv(2), 5);
    chclr = 4'b0100;
    cyc(1'b1, 2, 'h2EE, 1'b0, 0, 1'b0, 0);
    chclr = '0;
    chk("t5_clr_lvl2", lv(2), 0);
    chk("t5_clr_empt2", empt[2], 1);
    chk("t5_clr_ovf2", ovf[2], 0);
    chk("t5_clr_udf2", udf[2], 0);
    chk("t5_ch0_kept", lv(0), 5);
    chk("t5_udf1_kept", udf[1], 1);
    sclr = 1'b1;
    cyc(1'b1, 0, 'h55, 1'b1, 0, 1'b0, 0);
    sclr = 1'b0;
    chk("t5_sclr_empt", empt, 4'hf);
    chk("t5_sclr_flvl", flvl, 0);
    chk("t5_sclr_udf", udf, 0);
    chk("t5_sclr_ovf", ovf, 0);
    chk("t5_sclr_rvld", rvld, 0);
    wr(0, 'hE7);
    rd(0, 'hE7);
    idle();
    for (int k = 1; k <= 12; k++) begin
      wr(1, 'h100 + k);
      chk("t6_alme_up", alme[1], k <= 2);
      chk("t6_almf_up", almf[1], k >= 12);
    end
    for (int k = 1; k <= 12; k++) begin
      rd(1, 'h100 + k);
      chk("t6_alme_dn", alme[1], (12 - k) <= 2);
      chk("t6_almf_dn", almf[1], (12 - k) >= 12);
    end
    idle();
    wr(3, 'hF0);
    wr(3, 'hF1);
    cyc(1'b0, 0, 0, 1'b1, 3, 1'b0, 0);
    arst_n = 1'b0;
    #1;
    chk("t7_arst_lvl3", lv(3), 0);
    chk("t7_arst_empt", empt, 4'hf);
    chk("t7_arst_rvld", rvld, 0);
    chk("t7_arst_rdat", rdat, 0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    wr(3, 'hF5);
    rd(3, 'hF5);
    idle();
    idle();
    chk("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
